// File: rtl/mytimer2.sv
// rtl/mytimer2.sv - programmable interval timer with Avalon-MM-style slave port
//
// Purpose:
//   Down-counting interval timer used as a system tick or one-shot delay.
//   The counter reloads from PERIOD when it reaches zero while running. That
//   terminal count sets a sticky TO flag. A registered level interrupt is
//   raised while TO and the ITO enable are both set.
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   irq          out  1   level interrupt, registered TO & ITO
//   s_cs_n       in   1   slave chip select, active low
//   s_address    in   2   register word address
//   s_read       in   1   read strobe, qualified by ~s_cs_n
//   s_readdata   out  32  registered read data, one-cycle latency
//   s_write      in   1   write strobe, qualified by ~s_cs_n
//   s_writedata  in   32  write data
//
// Register map (word address):
//   0 STATUS   bit0 TO (sticky, any write clears), bit1 RUN (read-only)
//   1 CONTROL  bit0 ITO, bit1 CONT, bit2 START (pulse), bit3 STOP (pulse)
//   2 PERIOD   reload value, CNT_W bits, upper bits read as 0
//   3 SNAP     current counter, zero-extended, read-only

module mytimer2 #(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        irq,
    input  logic        s_cs_n,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    input  logic        s_write,
    input  logic [31:0] s_writedata
);

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_SNAP    = 2'd3;

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_to;
    logic             r_ito;
    logic             r_cont;
    logic             r_irq;
    logic [31:0]      r_readdata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_status;
    logic             w_wr_control;
    logic             w_wr_period;
    logic             w_start;
    logic             w_stop;
    logic [CNT_W-1:0] w_wdata_period;
    logic             w_run;
    logic             w_tc;
    logic             w_unused;

    assign w_wr           = ~s_cs_n & s_write;
    assign w_rd           = ~s_cs_n & s_read;
    assign w_wr_status    = w_wr && (s_address == ADDR_STATUS);
    assign w_wr_control   = w_wr && (s_address == ADDR_CONTROL);
    assign w_wr_period    = w_wr && (s_address == ADDR_PERIOD);
    assign w_start        = w_wr_control & s_writedata[2];
    assign w_stop         = w_wr_control & s_writedata[3];
    assign w_wdata_period = s_writedata[CNT_W-1:0];

    // Upper write-data bits above CNT_W are deliberately ignored.
    assign w_unused = &{1'b0, s_writedata};

    // Terminal count: running and the counter is already at zero this edge.
    assign w_tc = w_run && (r_count == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // STOP has priority over START. A START while running keeps the timer
    // running, even on a one-shot terminal count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start && !w_stop) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_start) begin
                    w_state_nxt = ST_RUNNING;
                end else if (w_tc && !r_cont) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_run = 1'b0;
        case (r_state)
            ST_IDLE:    w_run = 1'b0;
            ST_RUNNING: w_run = 1'b1;
            default:    w_run = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter
    // While running, the counter decrements each clock. It reloads on a
    // restart or at terminal count. While idle, it holds its value except
    // when PERIOD is written, so the next START counts the new period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RST_VAL;
        end else if (w_run) begin
            if (w_start && !w_stop) begin
                r_count <= r_period;
            end else if (w_tc) begin
                r_count <= r_period;
            end else begin
                r_count <= r_count - CNT_ONE;
            end
        end else if (w_wr_period) begin
            r_count <= w_wdata_period;
        end
    end

    // ------------------------------------------------------------------
    // Control and period registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= RST_VAL;
            r_ito    <= 1'b0;
            r_cont   <= 1'b0;
        end else begin
            if (w_wr_period) begin
                r_period <= w_wdata_period;
            end
            if (w_wr_control) begin
                r_ito  <= s_writedata[0];
                r_cont <= s_writedata[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag: a terminal count wins over a same-cycle clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to <= 1'b0;
        end else if (w_tc) begin
            r_to <= 1'b1;
        end else if (w_wr_status) begin
            r_to <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt: registered copy of TO & ITO, one clock behind either term.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_to & r_ito;
        end
    end

    assign irq = r_irq;

    // ------------------------------------------------------------------
    // Read data: captured on the read edge and held otherwise. SNAP
    // returns the counter as it stood before this edge's update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (w_rd) begin
            case (s_address)
                ADDR_STATUS:  r_readdata <= {30'd0, w_run, r_to};
                ADDR_CONTROL: r_readdata <= {30'd0, r_cont, r_ito};
                ADDR_PERIOD:  r_readdata <= 32'(r_period);
                ADDR_SNAP:    r_readdata <= 32'(r_count);
                default:      r_readdata <= 32'd0;
            endcase
        end
    end

    assign s_readdata = r_readdata;

endmodule

// File: tb/tb_mytimer2.sv
// tb/tb_mytimer2.sv - self-checking bench for mytimer2 with scenario tasks

module tb_mytimer2;

    logic        clk;
    logic        reset_n;
    logic        irq;
    logic        s_cs_n;
    logic [1:0]  s_address;
    logic        s_read;
    logic [31:0] s_readdata;
    logic        s_write;
    logic [31:0] s_writedata;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    localparam int RST_P = 50000;

    mytimer2 #(.CNT_W(16), .RESET_PERIOD(RST_P)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .s_cs_n      (s_cs_n),
        .s_address   (s_address),
        .s_read      (s_read),
        .s_readdata  (s_readdata),
        .s_write     (s_write),
        .s_writedata (s_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute edge counter; after the edge numbered E, cyc == E at the negedge.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (timer rules as arithmetic) ----------
    // A running timer at count C after edge S reaches terminal count at S+C+1,
    // and then every P+1 edges. The registered irq follows one edge later.
    function automatic int tc_edge(input int start_edge, input int start_count);
        return start_edge + start_count + 1;
    endfunction

    function automatic int irq_rise(input int to_edge);
        return to_edge + 1;
    endfunction

    // ---------------- bus tasks (called at a negedge, return at next) -------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_cs_n = 1'b1; s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
        @(negedge clk);
        s_cs_n = 1'b1; s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic wait_irq(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (irq === level) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (irq === level) ok = 1'b1;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", irq);
        else n_pass++;
        n_total++;
        if (s_readdata !== 32'd0) $display("FAIL reset_readdata: got %0h want 0", s_readdata);
        else n_pass++;
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(RST_P)) $display("FAIL reset_snap: got %0d want %0d", d, RST_P);
        else n_pass++;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL reset_status: got %0h want 0", d);
        else n_pass++;
        bus_read(2'd2, d);
        n_total++;
        if (d !== 32'(RST_P)) $display("FAIL reset_period: got %0d want %0d", d, RST_P);
        else n_pass++;
        bus_read(2'd1, d);
        n_total++;
        if (d !== 32'd0) $display("FAIL reset_control: got %0h want 0", d);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_idle_irq: got %0b want 0", irq);
        else n_pass++;
    endtask

    task automatic test_continuous(input int p);
        int  w;
        int  t1;
        int  t2;
        int  errs;
        bus_write(2'd2, 32'(p));
        bus_write(2'd1, 32'h7);            // ITO | CONT | START
        w  = cyc;
        t1 = tc_edge(w, p);
        t2 = t1 + p + 1;
        errs = 0;
        while (cyc < irq_rise(t1)) begin
            @(negedge clk);
            if (irq !== (cyc >= irq_rise(t1))) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL cont_first_irq p=%0d: %0d bad cycles, want rise at edge +%0d", p, errs, irq_rise(t1) - w);
        else n_pass++;
        bus_write(2'd0, 32'h0);            // clear TO, away from terminal count
        n_total++;
        if (irq !== 1'b1) $display("FAIL cont_clear_hold p=%0d: got %0b want 1", p, irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL cont_clear_drop p=%0d: got %0b want 0", p, irq);
        else n_pass++;
        errs = 0;
        while (cyc < irq_rise(t2)) begin
            @(negedge clk);
            if (irq !== (cyc >= irq_rise(t2))) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL cont_second_irq p=%0d: %0d bad cycles", p, errs);
        else n_pass++;
        bus_write(2'd1, 32'h8);            // STOP, ITO and CONT cleared
        bus_write(2'd0, 32'h0);
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL cont_stop_irq p=%0d: got %0b want 0", p, irq);
        else n_pass++;
    endtask

    task automatic test_oneshot(input int p);
        logic [31:0] d;
        int errs;
        bus_write(2'd2, 32'(p));
        bus_write(2'd1, 32'h4);            // START only: one-shot, no irq
        errs = 0;
        repeat (p + 3) begin
            @(negedge clk);
            if (irq !== 1'b0) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL oneshot_irq_low: %0d cycles with irq high", errs);
        else n_pass++;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL oneshot_status: got %0h want 1", d);
        else n_pass++;
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(p)) $display("FAIL oneshot_snap: got %0d want %0d", d, p);
        else n_pass++;
        bus_write(2'd1, 32'h1);            // enable ITO with TO already set
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_ito_early: got %0b want 0", irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL oneshot_ito_irq: got %0b want 1", irq);
        else n_pass++;
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h0);
    endtask

    task automatic test_stop_resume();
        logic [31:0] d;
        int w;
        int x;
        int k0;
        int v;
        bus_write(2'd2, 32'd20);
        bus_write(2'd1, 32'h6);            // CONT | START
        w  = cyc;
        k0 = 8 + int'($urandom_range(0, 3));
        repeat (k0 - 1) @(negedge clk);
        bus_write(2'd1, 32'hA);            // STOP, keep CONT
        x = cyc;
        v = 20 - (x - w);
        repeat (3) @(negedge clk);
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(v)) $display("FAIL stop_frozen: got %0d want %0d", d, v);
        else n_pass++;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL stop_status: got %0h want 0", d);
        else n_pass++;
        bus_write(2'd1, 32'h6);            // resume from held value
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(v)) $display("FAIL resume_value: got %0d want %0d", d, v);
        else n_pass++;
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(v - 1)) $display("FAIL resume_dec: got %0d want %0d", d, v - 1);
        else n_pass++;
        bus_write(2'd1, 32'h6);            // restart while running
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'd20) $display("FAIL restart_reload: got %0d want 20", d);
        else n_pass++;
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'd19) $display("FAIL restart_dec: got %0d want 19", d);
        else n_pass++;
        bus_write(2'd1, 32'h8);
        bus_write(2'd0, 32'h0);
    endtask

    task automatic test_period_and_reset();
        logic [31:0] d;
        bit ok;
        int p1;
        int w;
        int t1;
        int t2;
        int t3;
        bus_write(2'd2, 32'h1234_5678);
        bus_read(2'd2, d);
        n_total++;
        if (d !== 32'h0000_5678) $display("FAIL period_mask: got %0h want 5678", d);
        else n_pass++;
        p1 = int'($urandom_range(5, 12));
        bus_write(2'd2, 32'(p1));
        bus_write(2'd1, 32'h7);
        w = cyc;
        bus_write(2'd2, 32'd3);            // new period takes effect at reload
        bus_read(2'd2, d);
        n_total++;
        if (d !== 32'd3) $display("FAIL period_run_write: got %0d want 3", d);
        else n_pass++;
        t1 = tc_edge(w, p1);
        t2 = t1 + 4;
        t3 = t2 + 4;
        wait_irq(1'b1, 100, ok);
        n_total++;
        if (!ok || cyc != irq_rise(t1)) $display("FAIL period_first: irq rose at edge +%0d want +%0d", cyc - w, irq_rise(t1) - w);
        else n_pass++;
        bus_write(2'd0, 32'h0);
        wait_irq(1'b0, 20, ok);
        wait_irq(1'b1, 20, ok);
        n_total++;
        if (!ok || cyc != irq_rise(t2)) $display("FAIL period_next: irq rose at edge +%0d want +%0d", cyc - w, irq_rise(t2) - w);
        else n_pass++;
        while (cyc < t3 - 1) @(negedge clk);
        bus_write(2'd0, 32'h0);            // clear lands on terminal-count edge
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h3) $display("FAIL tc_vs_clear: got status %0h want 3", d);
        else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %0b want 1", irq);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL async_reset_irq: got %0b want 0", irq);
        else n_pass++;
        n_total++;
        if (s_readdata !== 32'd0) $display("FAIL async_reset_rdata: got %0h want 0", s_readdata);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd3, d);
        n_total++;
        if (d !== 32'(RST_P)) $display("FAIL post_reset_snap: got %0d want %0d", d, RST_P);
        else n_pass++;
        bus_read(2'd2, d);
        n_total++;
        if (d !== 32'(RST_P)) $display("FAIL post_reset_period: got %0d want %0d", d, RST_P);
        else n_pass++;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL post_reset_status: got %0h want 0", d);
        else n_pass++;
        bus_read(2'd1, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL post_reset_control: got %0h want 0", d);
        else n_pass++;
    endtask

    initial begin
        s_cs_n      = 1'b1;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_address   = 2'd0;
        s_writedata = 32'd0;
        reset_n     = 1'b0;
        test_reset();
        test_continuous(9);
        for (int i = 0; i < 2; i++) test_continuous(int'($urandom_range(3, 12)));
        test_oneshot(4);
        test_oneshot(int'($urandom_range(1, 10)));
        test_stop_resume();
        test_period_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
